// File: rtl/beeper_mixer.sv
// beeper_mixer: mixes CHANNELS 1-bit square-wave sources, each with its own volume,
// at a fractional sample rate. The mix goes through an optional one-pole low-pass
// and is driven out as two's complement or offset binary.
// Latency: CHANNELS+2 cycles from tick to sample_stb. A tick that arrives while busy is dropped and sets overrun.
module beeper_mixer #(
  parameter int CHANNELS   = 4,
  parameter int VOL_W      = 4,
  parameter int OUT_W      = 16,
  parameter int DIV_W      = 24,
  parameter int FILT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIV_W-1:0]          inc,
  input  logic [CHANNELS-1:0]       in_bits,
  input  logic [CHANNELS*VOL_W-1:0] vol,
  input  logic                      mute,
  input  logic                      out_signed,
  output logic [OUT_W-1:0]          audio_out,
  output logic                      sample_stb,
  output logic                      overrun
);
  localparam int SUM_W = VOL_W + $clog2(CHANNELS) + 1;
  localparam int ACC_W = OUT_W + FILT_SHIFT + 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SHL   = OUT_W - SUM_W;

  typedef enum logic [1:0] {IDLE, SUM, FILT, OUT} state_t;

  logic [CHANNELS-1:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0]          phase_q, phase_d;
  logic                      tick;
  state_t                    state_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [CHANNELS-1:0]       snap_bits_q;
  logic [CHANNELS*VOL_W-1:0] snap_vol_q;
  logic                      snap_mute_q, snap_signed_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          audio_q;
  logic                      stb_q, overrun_q;
  logic [VOL_W-1:0]          vol_ch;
  logic signed [SUM_W-1:0]   vol_ext, contrib;
  logic signed [OUT_W-1:0]   x, y;
  logic [OUT_W-1:0]          out_val;

  // Two-flop synchronizer for the asynchronous audio bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_bits;
      sync2_q <= sync1_q;
    end
  end

  // Carry out of the phase accumulator is the sample tick
  assign {tick, phase_d} = {1'b0, phase_q} + {1'b0, inc};

  // Phase accumulator wraps modulo 2^DIV_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  // Per-channel contribution, mix scaling, low-pass step and output format
  always_comb begin
    vol_ch  = snap_vol_q[int'(ch_q)*VOL_W +: VOL_W];
    vol_ext = $signed({{(SUM_W-VOL_W){1'b0}}, vol_ch});
    contrib = '0;
    if (!snap_mute_q) contrib = snap_bits_q[ch_q] ? vol_ext : -vol_ext;
    sum_d   = sum_q + contrib;
    x       = OUT_W'(sum_q) <<< SHL;
    acc_d   = acc_q + ACC_W'(x) - (acc_q >>> FILT_SHIFT);
    y       = (FILT_SHIFT == 0) ? x : OUT_W'(acc_d >>> FILT_SHIFT);
    out_val = snap_signed_q ? y : {~y[OUT_W-1], y[OUT_W-2:0]};
  end

  // Sequencer: snapshot on tick, one channel per cycle, filter, then present the sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      sum_q         <= '0;
      snap_bits_q   <= '0;
      snap_vol_q    <= '0;
      snap_mute_q   <= 1'b0;
      snap_signed_q <= 1'b0;
      acc_q         <= '0;
      audio_q       <= '0;
      stb_q         <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (tick && (state_q == SUM || state_q == FILT)) overrun_q <= 1'b1;
      case (state_q)
        IDLE, OUT: begin
          if (tick) begin
            snap_bits_q   <= sync2_q;
            snap_vol_q    <= vol;
            snap_mute_q   <= mute;
            snap_signed_q <= out_signed;
            sum_q         <= '0;
            ch_q          <= '0;
            state_q       <= SUM;
          end else begin
            state_q <= IDLE;
          end
        end
        SUM: begin
          sum_q <= sum_d;
          if (ch_q == CH_W'(CHANNELS - 1)) state_q <= FILT;
          else                             ch_q    <= ch_q + CH_W'(1);
        end
        FILT: begin
          if (FILT_SHIFT != 0) acc_q <= acc_d;
          audio_q <= out_val;
          stb_q   <= 1'b1;
          state_q <= OUT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign audio_out  = audio_q;
  assign sample_stb = stb_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_beeper_mixer.sv
// Self-checking bench for beeper_mixer: a bypass instance and a FILT_SHIFT=2 instance share stimulus.
module tb_beeper_mixer;
  localparam int C  = 4;
  localparam int VW = 4;
  localparam int OW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] inc;
  logic [C-1:0]  in_bits;
  logic [C*VW-1:0] vol;
  logic          mute, out_signed;
  logic [OW-1:0] aout0, aout1;
  logic          stb0, stb1, ovr0, ovr1;

  int     vectors = 0;
  int     errors  = 0;
  longint facc;

  beeper_mixer #(.CHANNELS(C), .VOL_W(VW), .OUT_W(OW), .DIV_W(DW), .FILT_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .inc(inc), .in_bits(in_bits), .vol(vol), .mute(mute),
    .out_signed(out_signed), .audio_out(aout0), .sample_stb(stb0), .overrun(ovr0));

  beeper_mixer #(.CHANNELS(C), .VOL_W(VW), .OUT_W(OW), .DIV_W(DW), .FILT_SHIFT(2)) dut1 (
    .clk(clk), .reset(reset), .inc(inc), .in_bits(in_bits), .vol(vol), .mute(mute),
    .out_signed(out_signed), .audio_out(aout1), .sample_stb(stb1), .overrun(ovr1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed mix sum: +vol for a high bit, -vol for a low bit, nothing when muted
  function automatic int model_sum(input logic [C-1:0] b, input logic [C*VW-1:0] v, input logic m);
    int s;
    s = 0;
    for (int i = 0; i < C; i++)
      if (!m) s += b[i] ? int'(v[i*VW +: VW]) : -int'(v[i*VW +: VW]);
    return s;
  endfunction

  function automatic logic [OW-1:0] fmt(input int yv, input logic sgn);
    logic [OW-1:0] w;
    w = OW'(yv);
    return sgn ? w : (w ^ 16'h8000);
  endfunction

  // One-pole low-pass with coefficient 1/4
  task automatic filt_model(input int xv, output logic [OW-1:0] yo);
    facc = facc + longint'(xv) - (facc >>> 2);
    yo   = OW'(facc >>> 2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    inc   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_inc(input logic [DW-1:0] v);
    @(posedge clk); #1;
    inc = v;
  endtask

  task automatic wait_stb(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (stb0 === 1'b1) ok = 1'b1;
    end
    vectors++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: sample_stb observed 0 for 40 cycles, expected 1", tag);
    end
  endtask

  // Apply inputs, let them settle past sync and an in-flight sample, then check the next sample
  task automatic drive_sample(input logic [C-1:0] b, input logic [C*VW-1:0] v, input logic m,
                              input logic sgn, input logic [OW-1:0] exp, input string tag);
    @(posedge clk); #1;
    in_bits = b; vol = v; mute = m; out_signed = sgn;
    repeat (12) @(posedge clk);
    wait_stb(tag);
    check(tag, aout0, exp);
  endtask

  // Cycle-level tick/strobe/overrun model: accepted ticks produce a strobe 6 cycles later and
  // the block is busy until then; ticks inside that window are dropped and set overrun.
  task automatic run_timing(input logic [DW-1:0] inc_v, input int n, input string tag);
    bit     stb_due[1100];
    int     next_free;
    bit     ov_exp;
    longint ph, lim;
    for (int i = 0; i < 1100; i++) stb_due[i] = 1'b0;
    next_free = 0;
    ov_exp    = 1'b0;
    ph        = 0;
    lim       = longint'(1) << DW;
    set_inc(inc_v);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check({tag, " stb"}, stb0, stb_due[c]);
      check({tag, " overrun"}, ovr0, ov_exp);
      if (ph + longint'(inc_v) >= lim) begin
        if (c >= next_free) begin
          if (c + 6 < 1100) stb_due[c+6] = 1'b1;
          next_free = c + 6;
        end else begin
          ov_exp = 1'b1;
        end
      end
      ph = (ph + longint'(inc_v)) % lim;
    end
  endtask

  initial begin
    logic [C-1:0]    b;
    logic [C*VW-1:0] v;
    logic            m, s;
    logic [OW-1:0]   yexp;
    int              xv;
    int              steps[3];
    steps = '{7680, 13440, 17760};

    reset = 1'b1; inc = '0; in_bits = '0; vol = '1; mute = 1'b0; out_signed = 1'b1;
    facc = 0;
    #1;
    check("rst audio0", aout0, 16'h0000);
    check("rst stb0", stb0, 1'b0);
    check("rst ovr0", ovr0, 1'b0);
    check("rst audio1", aout1, 16'h0000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed full-scale and format cases
    set_inc(24'(1 << 21));
    drive_sample(4'b1111, '1, 1'b0, 1'b1, 16'h7800, "signed all1");
    drive_sample(4'b0000, '1, 1'b0, 1'b1, 16'h8800, "signed all0");
    drive_sample(4'b0011, '1, 1'b0, 1'b1, 16'h0000, "signed 0011");
    drive_sample(4'b1111, '1, 1'b0, 1'b0, 16'hF800, "offset all1");
    drive_sample(4'b0000, '1, 1'b0, 1'b0, 16'h0800, "offset all0");
    drive_sample(4'b1010, '1, 1'b1, 1'b0, 16'h8000, "offset mute");

    // Randomized mixes against the sum model
    for (int k = 0; k < 24; k++) begin
      b = C'($urandom);
      v = (C*VW)'($urandom);
      m = ($urandom_range(0, 7) == 0);
      s = 1'($urandom);
      drive_sample(b, v, m, s, fmt(model_sum(b, v, m) * 512, s), "random mix");
    end
    check("no overrun at 8-cycle spacing", ovr0, 1'b0);

    // Tick-to-strobe latency, idle accumulator, and overrun behaviour
    do_reset();
    run_timing(24'(1 << 21), 64, "inc 2^21");
    do_reset();
    run_timing(24'd0, 1000, "inc 0");
    do_reset();
    run_timing(24'(1 << 22), 64, "inc 2^22");
    do_reset();
    check("overrun cleared by reset", ovr0, 1'b0);

    // Low-pass step response from reset
    do_reset();
    facc = 0;
    in_bits = '1; vol = '1; mute = 1'b0; out_signed = 1'b1;
    set_inc(24'(1 << 21));
    for (int k = 0; k < 60; k++) begin
      wait_stb("filt stb");
      filt_model(model_sum(4'b1111, '1, 1'b0) * 512, yexp);
      check("filt model", aout1, yexp);
      if (k < 3) check("filt step", aout1, 32'(steps[k]));
      check("filt bound", 32'($signed(aout1) <= 30720), 32'd1);
      check("bypass steady", aout0, 16'h7800);
    end
    check("filt converged", aout1, 16'd30720);

    // Reset asserted while summing
    do_reset();
    in_bits = '1; vol = '1; mute = 1'b0; out_signed = 1'b1;
    set_inc(24'(1 << 21));
    wait_stb("pre-reset stb");
    check("pre-reset audio", aout0, 16'h7800);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset audio0", aout0, 16'h0000);
    check("midreset stb0", stb0, 1'b0);
    check("midreset ovr0", ovr0, 1'b0);
    check("midreset audio1", aout1, 16'h0000);
    check("midreset stb1", stb1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    b = 4'b1011;
    v = (C*VW)'($urandom);
    in_bits = b; vol = v;
    facc = 0;
    wait_stb("post-reset stb");
    xv = model_sum(b, v, 1'b0) * 512;
    check("post-reset audio0", aout0, fmt(xv, 1'b1));
    filt_model(xv, yexp);
    check("post-reset audio1", aout1, yexp);
    check("post-reset ovr0", ovr0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
